// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/handshake/result bundle between sequencer, alu_pipe and writeback bus.
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             use_acc;
  logic             acc_wr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             v;
  logic             cout;
  logic             z;
  logic             n;
  logic [WIDTH-1:0] acc;
  modport master (output in_valid, a, b, op, use_acc, acc_wr, out_ready,
                  input  in_ready, out_valid, c, v, cout, z, n, acc);
  modport slave  (input  in_valid, a, b, op, use_acc, acc_wr, out_ready,
                  output in_ready, out_valid, c, v, cout, z, n, acc);
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered NAND/SUB/NOR/ADD ALU with valid/ready handshake and accumulator.
// Define ALU_SAT_EN to clamp signed-overflowing ADD/SUB results to the signed limit.
module alu_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic     clk,
  input logic     rst_n,
  alu_pipe_if.slave bus
);
  logic             accept, arith, ovf;
  logic [WIDTH-1:0] op_a, b_x, res_raw, res;
  logic [WIDTH:0]   sum;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] c_d, c_q, acc_d, acc_q;
  logic             v_d, v_q, cout_d, cout_q, z_d, z_q, n_d, n_q;
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.cout      = cout_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.acc       = acc_q;
  // op[0] marks the arithmetic ops; SUB (01) inverts b and injects carry-in
  always_comb begin
    accept  = bus.in_valid && bus.in_ready;
    arith   = bus.op[0];
    op_a    = bus.use_acc ? acc_q : bus.a;
    b_x     = bus.op[1] ? bus.b : ~bus.b;
    sum     = {1'b0, op_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, !bus.op[1]};
    ovf     = arith && (op_a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    res_raw = arith ? sum[WIDTH-1:0] : bus.op[1] ? ~(op_a | bus.b) : ~(op_a & bus.b);
`ifdef ALU_SAT_EN
    res     = !ovf ? res_raw : op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    res     = res_raw;
`endif
    out_valid_d = accept || (out_valid_q && !bus.out_ready);
    c_d    = accept ? res : c_q;
    v_d    = accept ? ovf : v_q;
    cout_d = accept ? (arith && sum[WIDTH]) : cout_q;
    z_d    = accept ? (res == '0) : z_q;
    n_d    = accept ? res[WIDTH-1] : n_q;
    acc_d  = (accept && bus.acc_wr) ? res : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      v_q         <= 1'b0;
      cout_q      <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      acc_q       <= ACC_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      v_q         <= v_d;
      cout_q      <= cout_d;
      z_q         <= z_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
    end
  end
endmodule
